// File: rtl/pc_redirect_ctrl_if.sv
// Instruction-memory fetch handshake between the PC sequencer (master) and imem (slave).
// Request is held with a stable address until ready is seen in the same cycle.
interface pc_redirect_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Fetch-side PC sequencer: owns the PC, drives the imem handshake, resolves EX redirects.
// Optional build macro PERF_CNT_EN adds branch/taken/wait performance counters.
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef PERF_CNT_EN
    ,
    parameter int          CNT_W    = 32
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_in,
    input  logic                   ex_valid,
    input  logic                   ex_branch,
    input  logic                   ex_jump,
    input  logic [2:0]             ex_funct3,
    input  logic                   ex_zero,
    input  logic                   ex_less,
    input  logic [31:0]            ex_target,
    pc_redirect_ctrl_if.master     imem,
    output logic                   redirect,
    output logic                   flush_if,
    output logic                   flush_id,
    output logic                   misalign_err,
    output logic [31:0]            misalign_addr
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]       perf_br,
    output logic [CNT_W-1:0]       perf_taken,
    output logic [CNT_W-1:0]       perf_wait
`endif
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] pend_reg;
    logic [31:0] pend_next;
    logic        hold_reg;
    logic        hold_next;
    logic        misalign_err_reg;
    logic        misalign_err_next;
    logic [31:0] misalign_addr_reg;
    logic [31:0] misalign_addr_next;

    logic        cond;
    logic        taken;
    logic        bad;
    logic        go;
    logic        go_run;
    logic        req;
    logic        stuck;

    // Branch condition; the ALU has already chosen signed/unsigned for ex_less.
    always_comb begin
        cond = 1'b0;
        case (ex_funct3)
            3'b000:  cond = ex_zero;
            3'b001:  cond = ~ex_zero;
            3'b100:  cond = ex_less;
            3'b101:  cond = ~ex_less;
            3'b110:  cond = ex_less;
            3'b111:  cond = ~ex_less;
            default: cond = 1'b0;
        endcase
    end

    assign taken = ex_valid & (ex_jump | (ex_branch & cond));
    assign bad   = taken & (ex_target[1:0] != 2'b00);
    assign go    = taken & ~bad;

    always_comb begin
        state_next         = state_reg;
        pc_next            = pc_reg;
        pend_next          = pend_reg;
        misalign_err_next  = 1'b0;
        misalign_addr_next = misalign_addr_reg;
        req                = 1'b0;
        stuck              = 1'b0;
        go_run             = 1'b0;
        redirect           = 1'b0;
        flush_if           = 1'b0;
        flush_id           = 1'b0;

        if (!rst) begin
            req = hold_reg | ~stall_in;
            case (state_reg)
                RUN: begin
                    stuck  = req & ~imem.imem_ready;
                    go_run = go;
                    if (go && !stuck) begin
                        // Any fetch accepted this cycle is wrong-path; flush_if kills it.
                        pc_next  = ex_target;
                        redirect = 1'b1;
                        flush_if = 1'b1;
                        flush_id = 1'b1;
                    end else if (go && stuck) begin
                        // Address must stay stable until imem accepts; park the target.
                        pend_next  = ex_target;
                        flush_id   = 1'b1;
                        state_next = WAIT_ACK;
                    end else if (req && imem.imem_ready) begin
                        pc_next = pc_reg + 32'd4;
                    end
                    if (bad) begin
                        misalign_err_next  = 1'b1;
                        misalign_addr_next = ex_target;
                    end
                end
                WAIT_ACK: begin
                    req = 1'b1;
                    if (imem.imem_ready) begin
                        flush_if   = 1'b1;
                        redirect   = 1'b1;
                        pc_next    = pend_reg;
                        state_next = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
        hold_next = req & ~imem.imem_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= RUN;
            pc_reg            <= RESET_PC;
            pend_reg          <= 32'h0;
            hold_reg          <= 1'b0;
            misalign_err_reg  <= 1'b0;
            misalign_addr_reg <= 32'h0;
        end else begin
            state_reg         <= state_next;
            pc_reg            <= pc_next;
            pend_reg          <= pend_next;
            hold_reg          <= hold_next;
            misalign_err_reg  <= misalign_err_next;
            misalign_addr_reg <= misalign_addr_next;
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_reg;
    assign misalign_err   = misalign_err_reg;
    assign misalign_addr  = misalign_addr_reg;

`ifdef PERF_CNT_EN
    // Event bit order: 0 = branch seen, 1 = redirect taken, 2 = waiting on ack.
    logic [2:0] perf_evt;
    assign perf_evt = {state_reg == WAIT_ACK, go_run, ex_valid & ex_branch};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_perf
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (perf_evt[gi]) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign perf_br    = g_perf[0].cnt_reg;
    assign perf_taken = g_perf[1].cnt_reg;
    assign perf_wait  = g_perf[2].cnt_reg;
`else
    logic unused_go_run;
    assign unused_go_run = go_run;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: per-cycle stimulus rows with expected outputs
// pushed to a scoreboard queue and compared at the falling edge.
module tb_pc_redirect_ctrl;

    logic        clk;
    logic        rst;
    logic        stall_in;
    logic        ex_valid;
    logic        ex_branch;
    logic        ex_jump;
    logic [2:0]  ex_funct3;
    logic        ex_zero;
    logic        ex_less;
    logic [31:0] ex_target;
    logic        redirect;
    logic        flush_if;
    logic        flush_id;
    logic        misalign_err;
    logic [31:0] misalign_addr;
`ifdef PERF_CNT_EN
    logic [31:0] perf_br;
    logic [31:0] perf_taken;
    logic [31:0] perf_wait;
`endif

    pc_redirect_ctrl_if bus ();

    pc_redirect_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stall_in     (stall_in),
        .ex_valid     (ex_valid),
        .ex_branch    (ex_branch),
        .ex_jump      (ex_jump),
        .ex_funct3    (ex_funct3),
        .ex_zero      (ex_zero),
        .ex_less      (ex_less),
        .ex_target    (ex_target),
        .imem         (bus.master),
        .redirect     (redirect),
        .flush_if     (flush_if),
        .flush_id     (flush_id),
        .misalign_err (misalign_err),
        .misalign_addr(misalign_addr)
`ifdef PERF_CNT_EN
        ,
        .perf_br      (perf_br),
        .perf_taken   (perf_taken),
        .perf_wait    (perf_wait)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // exp = {imem_req, imem_addr, redirect, flush_if, flush_id, misalign_err, misalign_addr}
    typedef struct {
        logic        stall;
        logic        v;
        logic        br;
        logic        jmp;
        logic [2:0]  f3;
        logic        z;
        logic        ls;
        logic [31:0] tgt;
        logic        rdy;
        logic [68:0] exp;
    } row_t;

    logic [68:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic row_t r(input logic stall, input logic v, input logic br, input logic jmp,
                               input logic [2:0] f3, input logic z, input logic ls,
                               input logic [31:0] tgt, input logic rdy,
                               input logic req, input logic [31:0] addr, input logic rd,
                               input logic fi, input logic fd, input logic me,
                               input logic [31:0] ma);
        row_t x;
        x.stall = stall; x.v = v; x.br = br; x.jmp = jmp; x.f3 = f3;
        x.z = z; x.ls = ls; x.tgt = tgt; x.rdy = rdy;
        x.exp = {req, addr, rd, fi, fd, me, ma};
        return x;
    endfunction

    task automatic drive(input row_t x);
        stall_in       = x.stall;
        ex_valid       = x.v;
        ex_branch      = x.br;
        ex_jump        = x.jmp;
        ex_funct3      = x.f3;
        ex_zero        = x.z;
        ex_less        = x.ls;
        ex_target      = x.tgt;
        bus.imem_ready = x.rdy;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(r(0,0,0,0,3'b000,0,0,32'h0,1, 0,32'h0,0,0,0,0,32'h0));
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        row_t rows[$];
        logic [68:0] obs, expv;
        rst = 1'b1;
        drive(r(0,0,0,0,3'b000,0,0,32'h0,1, 0,32'h0,0,0,0,0,32'h0));
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({1'b0, 32'h0, 3'b000, 1'b0, 32'h0});
            @(negedge clk);
            obs  = {bus.imem_req, bus.imem_addr, redirect, flush_if, flush_id, misalign_err, misalign_addr};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL test_reset in_reset %0d: got %h, expected %h", k, obs, expv);
            end else $display("ok   test_reset in_reset %0d: %h", k, obs);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        rows.push_back(r(0,0,0,0,3'b000,0,0,32'h0,1, 1,32'h0,0,0,0,0,32'h0));
        rows.push_back(r(0,0,0,0,3'b000,0,0,32'h0,1, 1,32'h4,0,0,0,0,32'h0));
        rows.push_back(r(0,0,0,0,3'b000,0,0,32'h0,1, 1,32'h8,0,0,0,0,32'h0));
        foreach (rows[i]) begin
            drive(rows[i]);
            exp_q.push_back(rows[i].exp);
            @(negedge clk);
            obs  = {bus.imem_req, bus.imem_addr, redirect, flush_if, flush_id, misalign_err, misalign_addr};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL test_reset row %0d: got %h, expected %h", i, obs, expv);
            end else $display("ok   test_reset row %0d: %h", i, obs);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        row_t rows[$];
        logic [68:0] obs, expv;
        do_reset();
        rows.push_back(r(0,0,0,0,3'b000,0,0,32'h0,  1, 1,32'h0,  0,0,0,0,32'h0)); // step
        rows.push_back(r(0,1,1,0,3'b000,1,0,32'h100,1, 1,32'h4,  1,1,1,0,32'h0)); // BEQ taken
        rows.push_back(r(0,0,0,0,3'b000,0,0,32'h0,  1, 1,32'h100,0,0,0,0,32'h0));
        rows.push_back(r(0,1,1,0,3'b000,0,0,32'h300,1, 1,32'h104,0,0,0,0,32'h0)); // BEQ not taken
        rows.push_back(r(0,0,0,0,3'b000,0,0,32'h0,  1, 1,32'h108,0,0,0,0,32'h0));
        rows.push_back(r(0,1,1,0,3'b100,0,1,32'h40, 1, 1,32'h10c,1,1,1,0,32'h0)); // BLT taken
        rows.push_back(r(0,0,0,0,3'b000,0,0,32'h0,  1, 1,32'h40, 0,0,0,0,32'h0));
        rows.push_back(r(0,1,1,0,3'b111,0,1,32'h400,1, 1,32'h44, 0,0,0,0,32'h0)); // BGEU not taken
        rows.push_back(r(0,1,1,0,3'b010,1,0,32'h400,1, 1,32'h48, 0,0,0,0,32'h0)); // funct3 010
        rows.push_back(r(0,0,0,0,3'b000,0,0,32'h0,  1, 1,32'h4c, 0,0,0,0,32'h0));
        rows.push_back(r(0,0,0,1,3'b000,0,0,32'h500,1, 1,32'h50, 0,0,0,0,32'h0)); // jump, not valid
        rows.push_back(r(0,0,0,0,3'b000,0,0,32'h0,  1, 1,32'h54, 0,0,0,0,32'h0));
        rows.push_back(r(0,1,1,1,3'b000,0,0,32'h80, 1, 1,32'h58, 1,1,1,0,32'h0)); // jump beats branch
        rows.push_back(r(0,0,0,0,3'b000,0,0,32'h0,  1, 1,32'h80, 0,0,0,0,32'h0));
        foreach (rows[i]) begin
            drive(rows[i]);
            exp_q.push_back(rows[i].exp);
            @(negedge clk);
            obs  = {bus.imem_req, bus.imem_addr, redirect, flush_if, flush_id, misalign_err, misalign_addr};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL test_branch row %0d: got %h, expected %h", i, obs, expv);
            end else $display("ok   test_branch row %0d: %h", i, obs);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wait_ack();
        row_t rows[$];
        logic [68:0] obs, expv;
        do_reset();
        rows.push_back(r(0,1,0,1,3'b000,0,0,32'h20, 1, 1,32'h0,  1,1,1,0,32'h0)); // JAL to 0x20
        rows.push_back(r(0,1,0,1,3'b000,0,0,32'h200,0, 1,32'h20, 0,0,1,0,32'h0)); // JAL while stuck
        rows.push_back(r(0,1,0,1,3'b000,0,0,32'h700,0, 1,32'h20, 0,0,0,0,32'h0)); // EX ignored
        rows.push_back(r(1,0,0,0,3'b000,0,0,32'h0,  0, 1,32'h20, 0,0,0,0,32'h0)); // stall ignored
        rows.push_back(r(0,0,0,0,3'b000,0,0,32'h0,  1, 1,32'h20, 1,1,0,0,32'h0)); // ack
        rows.push_back(r(0,0,0,0,3'b000,0,0,32'h0,  1, 1,32'h200,0,0,0,0,32'h0));
        foreach (rows[i]) begin
            drive(rows[i]);
            exp_q.push_back(rows[i].exp);
            @(negedge clk);
            obs  = {bus.imem_req, bus.imem_addr, redirect, flush_if, flush_id, misalign_err, misalign_addr};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL test_wait_ack row %0d: got %h, expected %h", i, obs, expv);
            end else $display("ok   test_wait_ack row %0d: %h", i, obs);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_misalign();
        row_t rows[$];
        logic [68:0] obs, expv;
        do_reset();
        rows.push_back(r(0,0,0,0,3'b000,0,0,32'h0,  1, 1,32'h0, 0,0,0,0,32'h0));
        rows.push_back(r(0,1,1,0,3'b001,0,0,32'h102,1, 1,32'h4, 0,0,0,0,32'h0)); // BNE bad target
        rows.push_back(r(0,0,0,0,3'b000,0,0,32'h0,  1, 1,32'h8, 0,0,0,1,32'h102));
        rows.push_back(r(0,0,0,0,3'b000,0,0,32'h0,  1, 1,32'hc, 0,0,0,0,32'h102));
        rows.push_back(r(0,1,1,0,3'b000,0,0,32'h3,  1, 1,32'h10,0,0,0,0,32'h102)); // not taken
        rows.push_back(r(0,0,0,0,3'b000,0,0,32'h0,  1, 1,32'h14,0,0,0,0,32'h102));
        foreach (rows[i]) begin
            drive(rows[i]);
            exp_q.push_back(rows[i].exp);
            @(negedge clk);
            obs  = {bus.imem_req, bus.imem_addr, redirect, flush_if, flush_id, misalign_err, misalign_addr};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL test_misalign row %0d: got %h, expected %h", i, obs, expv);
            end else $display("ok   test_misalign row %0d: %h", i, obs);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall_wrap();
        row_t rows[$];
        logic [68:0] obs, expv;
        do_reset();
        rows.push_back(r(0,0,0,0,3'b000,0,0,32'h0,        1, 1,32'h0,        0,0,0,0,32'h0));
        rows.push_back(r(1,0,0,0,3'b000,0,0,32'h0,        1, 0,32'h4,        0,0,0,0,32'h0));
        rows.push_back(r(1,0,0,0,3'b000,0,0,32'h0,        1, 0,32'h4,        0,0,0,0,32'h0));
        rows.push_back(r(0,0,0,0,3'b000,0,0,32'h0,        0, 1,32'h4,        0,0,0,0,32'h0));
        rows.push_back(r(1,0,0,0,3'b000,0,0,32'h0,        0, 1,32'h4,        0,0,0,0,32'h0)); // hold
        rows.push_back(r(1,0,0,0,3'b000,0,0,32'h0,        1, 1,32'h4,        0,0,0,0,32'h0)); // accepted
        rows.push_back(r(1,0,0,0,3'b000,0,0,32'h0,        1, 0,32'h8,        0,0,0,0,32'h0));
        rows.push_back(r(0,1,0,1,3'b000,0,0,32'hfffffffc, 1, 1,32'h8,        1,1,1,0,32'h0));
        rows.push_back(r(0,0,0,0,3'b000,0,0,32'h0,        1, 1,32'hfffffffc, 0,0,0,0,32'h0));
        rows.push_back(r(0,0,0,0,3'b000,0,0,32'h0,        1, 1,32'h0,        0,0,0,0,32'h0)); // wrapped
        rows.push_back(r(1,1,0,1,3'b000,0,0,32'h60,       0, 0,32'h4,        1,1,1,0,32'h0)); // go while stalled
        rows.push_back(r(0,0,0,0,3'b000,0,0,32'h0,        1, 1,32'h60,       0,0,0,0,32'h0));
        foreach (rows[i]) begin
            drive(rows[i]);
            exp_q.push_back(rows[i].exp);
            @(negedge clk);
            obs  = {bus.imem_req, bus.imem_addr, redirect, flush_if, flush_id, misalign_err, misalign_addr};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL test_stall_wrap row %0d: got %h, expected %h", i, obs, expv);
            end else $display("ok   test_stall_wrap row %0d: %h", i, obs);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        logic [68:0] obs, expv;
        do_reset();
        rows.push_back(r(0,1,0,1,3'b000,0,0,32'h10,1, 1,32'h0, 1,1,1,0,32'h0));
        rows.push_back(r(0,1,0,1,3'b000,0,0,32'h30,1, 1,32'h10,1,1,1,0,32'h0));
        rows.push_back(r(0,1,1,0,3'b101,0,0,32'h8, 1, 1,32'h30,1,1,1,0,32'h0)); // BGE taken
        rows.push_back(r(0,0,0,0,3'b000,0,0,32'h0, 1, 1,32'h8, 0,0,0,0,32'h0));
        foreach (rows[i]) begin
            drive(rows[i]);
            exp_q.push_back(rows[i].exp);
            @(negedge clk);
            obs  = {bus.imem_req, bus.imem_addr, redirect, flush_if, flush_id, misalign_err, misalign_addr};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL test_back_to_back row %0d: got %h, expected %h", i, obs, expv);
            end else $display("ok   test_back_to_back row %0d: %h", i, obs);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_perf();
        row_t rows[$];
        logic [68:0] obs, expv;
        do_reset();
        rows.push_back(r(0,1,1,0,3'b000,1,0,32'h40,1, 1,32'h0, 1,1,1,0,32'h0)); // taken
        rows.push_back(r(0,1,1,0,3'b000,0,0,32'h90,1, 1,32'h40,0,0,0,0,32'h0)); // not taken
        rows.push_back(r(0,1,1,0,3'b000,1,0,32'h80,0, 1,32'h44,0,0,1,0,32'h0)); // taken, stuck
        rows.push_back(r(0,0,0,0,3'b000,0,0,32'h0, 0, 1,32'h44,0,0,0,0,32'h0));
        rows.push_back(r(0,0,0,0,3'b000,0,0,32'h0, 0, 1,32'h44,0,0,0,0,32'h0));
        rows.push_back(r(0,0,0,0,3'b000,0,0,32'h0, 1, 1,32'h44,1,1,0,0,32'h0));
        rows.push_back(r(0,0,0,0,3'b000,0,0,32'h0, 1, 1,32'h80,0,0,0,0,32'h0));
        foreach (rows[i]) begin
            drive(rows[i]);
            exp_q.push_back(rows[i].exp);
            @(negedge clk);
            obs  = {bus.imem_req, bus.imem_addr, redirect, flush_if, flush_id, misalign_err, misalign_addr};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL test_perf row %0d: got %h, expected %h", i, obs, expv);
            end else $display("ok   test_perf row %0d: %h", i, obs);
            @(posedge clk); #1;
        end
`ifdef PERF_CNT_EN
        checks++;
        if (perf_br !== 32'd3) begin
            errors++;
            $display("FAIL test_perf perf_br: got %0d, expected 3", perf_br);
        end else $display("ok   test_perf perf_br=%0d", perf_br);
        checks++;
        if (perf_taken !== 32'd2) begin
            errors++;
            $display("FAIL test_perf perf_taken: got %0d, expected 2", perf_taken);
        end else $display("ok   test_perf perf_taken=%0d", perf_taken);
        checks++;
        if (perf_wait !== 32'd3) begin
            errors++;
            $display("FAIL test_perf perf_wait: got %0d, expected 3", perf_wait);
        end else $display("ok   test_perf perf_wait=%0d", perf_wait);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_branch();
        test_wait_ack();
        test_misalign();
        test_stall_wrap();
        test_back_to_back();
        test_perf();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
